// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and limits for the bit-serial adder
// Purpose: FSM state encoding and width limit used by serial_adder.
// Ports:   none (package).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/result handshake bundle of the bit-serial adder
// Purpose: groups operand request and result signals; master drives requests,
//          slave (the adder) drives results.
// Signals: i_start, i_a[WIDTH], i_b[WIDTH], i_cin (only with SERIAL_ADDER_CIN_EN),
//          o_ready, o_valid, o_sum[WIDTH], o_carry.
// Config:  SERIAL_ADDER_CIN_EN adds the carry-in signal.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
`ifdef SERIAL_ADDER_CIN_EN
  logic             i_cin;
`endif
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;

  modport master (
`ifdef SERIAL_ADDER_CIN_EN
    output i_cin,
`endif
    output i_start, i_a, i_b,
    input  o_ready, o_valid, o_sum, o_carry
  );

  modport slave (
`ifdef SERIAL_ADDER_CIN_EN
    input  i_cin,
`endif
    input  i_start, i_a, i_b,
    output o_ready, o_valid, o_sum, o_carry
  );

endinterface

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational one-bit full adder
// Purpose: one-bit full adder made of two cascaded half-adder stages whose
//          carries are ORed.
// Ports:   a, b, cin (in, 1 bit); s, cout (out, 1 bit).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  // first half adder: a + b
  assign s1 = a ^ b;
  assign c1 = a & b;

  // second half adder: partial sum + cin
  assign s  = s1 ^ cin;
  assign c2 = s1 & cin;

  // at most one of the two half-adder carries can be set
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - WIDTH-bit LSB-first bit-serial adder with parallel result
// Purpose: captures A/B on an accepted start, adds one bit per clock through a
//          full_adder_cell and a carry flip-flop, then presents sum and carry-out
//          with a one-cycle valid pulse.
// Ports:   i_clk (in), i_rst_n (in, async active-low),
//          bus (serial_adder_if.slave: i_start, i_a, i_b, [i_cin], o_ready,
//          o_valid, o_sum, o_carry).
// Params:  WIDTH 1..32 (default 8).
// Config:  SERIAL_ADDER_CIN_EN adds carry-in; otherwise carry-in is 0.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry_ff;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_c;
  logic             last_bit;
  logic             cin_load;
  logic             ready;
  logic             valid;

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_ff),
    .s    (bit_s),
    .cout (bit_c)
  );

  // new sum bit enters at the MSB so the LSB-first stream lands in place
  if (WIDTH == 1) begin : g_res_one
    assign res_nxt = bit_s;
  end else begin : g_res_many
    assign res_nxt = {bit_s, res_sr[WIDTH-1:1]};
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_CIN_EN
  assign cin_load = bus.i_cin;
`else
  assign cin_load = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = RUN;
      RUN:     if (last_bit)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      DONE:    valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            a_sr     <= bus.i_a;
            b_sr     <= bus.i_b;
            carry_ff <= cin_load;
            cnt      <= '0;
          end
        end
        RUN: begin
          res_sr   <= res_nxt;
          carry_ff <= bit_c;
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          cnt      <= cnt + CW'(1);
          // outputs are loaded only with the completed word, never partials
          if (last_bit) begin
            sum_q   <= res_nxt;
            carry_q <= bit_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = valid;
  assign bus.o_sum   = sum_q;
  assign bus.o_carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 i_clk = ~i_clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus8.slave)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // edges counted from the accept edge (edge 1) until o_valid is seen
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] es, input logic ec, input string tag);
    int   edges;
    logic seen;
    logic rdy_hi;
    @(negedge i_clk);
    chk({tag, "/ready_idle"}, 32'(bus8.o_ready), 32'd1);
    bus8.i_a = a;
    bus8.i_b = b;
`ifdef SERIAL_ADDER_CIN_EN
    bus8.i_cin = cin;
`else
    if (cin) $display("note: %s carry-in ignored in this build", tag);
`endif
    bus8.i_start = 1'b1;
    @(posedge i_clk);
    #1 bus8.i_start = 1'b0;
    edges  = 1;
    seen   = 1'b0;
    rdy_hi = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge i_clk);
      if (bus8.o_valid) begin
        seen = 1'b1;
      end else begin
        if (bus8.o_ready) rdy_hi = 1'b1;
        @(posedge i_clk);
        edges++;
      end
    end
    chk({tag, "/valid_seen"}, 32'(seen), 32'd1);
    chk({tag, "/latency"}, 32'(edges), 32'd9);
    chk({tag, "/ready_run"}, 32'(rdy_hi | bus8.o_ready), 32'd0);
    chk({tag, "/sum"}, 32'(bus8.o_sum), 32'(es));
    chk({tag, "/carry"}, 32'(bus8.o_carry), 32'(ec));
    @(negedge i_clk);
    chk({tag, "/valid_pulse"}, 32'(bus8.o_valid), 32'd0);
    chk({tag, "/sum_hold"}, 32'(bus8.o_sum), 32'(es));
  endtask

  logic [7:0] t5_a [4] = '{8'd10, 8'h80, 8'hAA, 8'h7F};
  logic [7:0] t5_b [4] = '{8'd20, 8'h80, 8'h55, 8'h01};
  logic [7:0] t5_s [4] = '{8'd30, 8'h00, 8'hFF, 8'h80};
  logic       t5_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int   nvalid;
    int   cyc;
    int   last_cyc;
    int   edges;
    logic seen;
    logic [7:0] vsum;

    bus8.i_start = 1'b0;
    bus8.i_a = '0;
    bus8.i_b = '0;
    bus1.i_start = 1'b0;
    bus1.i_a = '0;
    bus1.i_b = '0;
`ifdef SERIAL_ADDER_CIN_EN
    bus8.i_cin = 1'b0;
    bus1.i_cin = 1'b0;
`endif

    // reset state
    repeat (2) @(negedge i_clk);
    chk("rst/ready", 32'(bus8.o_ready), 32'd1);
    chk("rst/valid", 32'(bus8.o_valid), 32'd0);
    chk("rst/sum", 32'(bus8.o_sum), 32'd0);
    chk("rst/carry", 32'(bus8.o_carry), 32'd0);
    i_rst_n = 1'b1;

    // basic add and wrap-around
    op8(8'd4, 8'd5, 1'b0, 8'd9, 1'b0, "t1");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
    op8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "t2b");
`ifdef SERIAL_ADDER_CIN_EN
    op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "t6cin");
    op8(8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, "t6cin0");
`else
    op8(8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, "t2c");
`endif

    // start pulse during RUN is ignored
    @(negedge i_clk);
    bus8.i_a = 8'd3;
    bus8.i_b = 8'd3;
    bus8.i_start = 1'b1;
    @(posedge i_clk);
    #1 bus8.i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    bus8.i_a = 8'd1;
    bus8.i_b = 8'd1;
    bus8.i_start = 1'b1;
    @(posedge i_clk);
    #1 bus8.i_start = 1'b0;
    nvalid = 0;
    vsum = 8'hxx;
    repeat (15) begin
      @(negedge i_clk);
      if (bus8.o_valid) begin
        nvalid++;
        vsum = bus8.o_sum;
      end
    end
    chk("t3/nvalid", 32'(nvalid), 32'd1);
    chk("t3/sum", 32'(vsum), 32'd6);
    chk("t3/carry", 32'(bus8.o_carry), 32'd0);

    // reset in the middle of RUN abandons the op
    @(negedge i_clk);
    bus8.i_a = 8'd4;
    bus8.i_b = 8'd5;
    bus8.i_start = 1'b1;
    @(posedge i_clk);
    #1 bus8.i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    chk("t4/sum", 32'(bus8.o_sum), 32'd0);
    chk("t4/ready", 32'(bus8.o_ready), 32'd1);
    chk("t4/valid", 32'(bus8.o_valid), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    nvalid = 0;
    repeat (15) begin
      @(negedge i_clk);
      if (bus8.o_valid) nvalid++;
    end
    chk("t4/no_valid", 32'(nvalid), 32'd0);
    chk("t4/sum_after", 32'(bus8.o_sum), 32'd0);

    // start held high: back-to-back ops every WIDTH+2 cycles
    @(negedge i_clk);
    bus8.i_a = t5_a[0];
    bus8.i_b = t5_b[0];
    bus8.i_start = 1'b1;
    nvalid = 0;
    cyc = 0;
    last_cyc = 0;
    for (int i = 0; i < 60 && nvalid < 4; i++) begin
      @(negedge i_clk);
      cyc++;
      if (bus8.o_valid) begin
        chk($sformatf("t5/sum%0d", nvalid), 32'(bus8.o_sum), 32'(t5_s[nvalid]));
        chk($sformatf("t5/carry%0d", nvalid), 32'(bus8.o_carry), 32'(t5_c[nvalid]));
        if (nvalid > 0)
          chk($sformatf("t5/gap%0d", nvalid), 32'(cyc - last_cyc), 32'd10);
        last_cyc = cyc;
        nvalid++;
        if (nvalid < 4) begin
          bus8.i_a = t5_a[nvalid];
          bus8.i_b = t5_b[nvalid];
        end else begin
          bus8.i_start = 1'b0;
        end
      end
    end
    bus8.i_start = 1'b0;
    chk("t5/count", 32'(nvalid), 32'd4);

    // WIDTH=1 instance
    @(negedge i_clk);
    bus1.i_a = 1'b1;
    bus1.i_b = 1'b1;
    bus1.i_start = 1'b1;
    @(posedge i_clk);
    #1 bus1.i_start = 1'b0;
    edges = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge i_clk);
      if (bus1.o_valid) begin
        seen = 1'b1;
      end else begin
        @(posedge i_clk);
        edges++;
      end
    end
    chk("w1/valid_seen", 32'(seen), 32'd1);
    chk("w1/latency", 32'(edges), 32'd2);
    chk("w1/sum", 32'(bus1.o_sum), 32'd0);
    chk("w1/carry", 32'(bus1.o_carry), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
